// File: rtl/mem_pkg.sv
// Shared definitions for the two-port memory arbiter: port indices, default widths
// and the request bundle that is muxed onto the single-port memory.
package mem_pkg;

    localparam int PORT_CPU       = 0;
    localparam int PORT_AUX       = 1;
    localparam int ADDR_WIDTH_DEF = 14;
    localparam int MEM_ADDR_MAX   = 32;

    // addr is sized for the widest legal ADDR_WIDTH; users slice the low bits
    typedef struct packed {
        logic                    write;
        logic [3:0]              wmask;
        logic [31:0]             wdata;
        logic                    wgrubby;
        logic [MEM_ADDR_MAX-1:0] addr;
    } mem_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory signals of the arbiter; slave is the arbiter's view,
// master is the combined requester/memory view.
interface mem_arbiter_if #(parameter int ADDR_WIDTH = mem_pkg::ADDR_WIDTH_DEF);

    logic                  p0_valid, p0_ready, p0_write, p0_wgrubby;
    logic [3:0]            p0_wmask;
    logic [31:0]           p0_wdata, p0_rdata;
    logic [ADDR_WIDTH-1:0] p0_addr;
    logic                  p0_rgrubby, p0_rvalid;

    logic                  p1_valid, p1_ready, p1_write, p1_wgrubby;
    logic [3:0]            p1_wmask;
    logic [31:0]           p1_wdata, p1_rdata;
    logic [ADDR_WIDTH-1:0] p1_addr;
    logic                  p1_rgrubby, p1_rvalid;

    logic                  mem_write, mem_wgrubby, mem_rgrubby;
    logic [3:0]            mem_wmask;
    logic [31:0]           mem_wdata, mem_rdata;
    logic [ADDR_WIDTH-1:0] mem_addr;

    modport slave (
        input  p0_valid, p0_write, p0_wmask, p0_wdata, p0_wgrubby, p0_addr,
        input  p1_valid, p1_write, p1_wmask, p1_wdata, p1_wgrubby, p1_addr,
        input  mem_rdata, mem_rgrubby,
        output p0_ready, p0_rdata, p0_rgrubby, p0_rvalid,
        output p1_ready, p1_rdata, p1_rgrubby, p1_rvalid,
        output mem_write, mem_wmask, mem_wdata, mem_wgrubby, mem_addr
    );

    modport master (
        output p0_valid, p0_write, p0_wmask, p0_wdata, p0_wgrubby, p0_addr,
        output p1_valid, p1_write, p1_wmask, p1_wdata, p1_wgrubby, p1_addr,
        output mem_rdata, mem_rgrubby,
        input  p0_ready, p0_rdata, p0_rgrubby, p0_rvalid,
        input  p1_ready, p1_rdata, p1_rgrubby, p1_rvalid,
        input  mem_write, mem_wmask, mem_wdata, mem_wgrubby, mem_addr
    );

endinterface

// File: rtl/mem_arb_starve.sv
// Saturating count of consecutive cycles port 1 was refused; force_p1_o flags
// that the limit is reached and port 1 must win the next contested cycle.
module mem_arb_starve #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic p1_valid_i,
    input  logic p1_ready_i,
    output logic force_p1_o
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!p1_valid_i || p1_ready_i) begin
            cnt_d = 8'd0;
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_p1_o = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Fixed-priority arbiter (port 0 over port 1, with starvation override) sharing one
// single-port memory; routes the one-cycle read response back to the issuing port.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int STARVE_LIMIT = 8
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    logic     force_p1, grant0, grant1, any_grant;
    logic     rsel_q, rsel_d, rpend_q, rpend_d;
    mem_req_t req0, req1, sel;

    mem_arb_starve #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
        .clk        (clk),
        .rst        (rst),
        .p1_valid_i (bus.p1_valid),
        .p1_ready_i (bus.p1_ready),
        .force_p1_o (force_p1)
    );

    always_comb begin
        grant1    = bus.p1_valid & (~bus.p0_valid | force_p1);
        grant0    = bus.p0_valid & ~grant1;
        any_grant = grant0 | grant1;

        req0.write   = bus.p0_write;
        req0.wmask   = bus.p0_wmask;
        req0.wdata   = bus.p0_wdata;
        req0.wgrubby = bus.p0_wgrubby;
        req0.addr    = MEM_ADDR_MAX'(bus.p0_addr);
        req1.write   = bus.p1_write;
        req1.wmask   = bus.p1_wmask;
        req1.wdata   = bus.p1_wdata;
        req1.wgrubby = bus.p1_wgrubby;
        req1.addr    = MEM_ADDR_MAX'(bus.p1_addr);

        // idle cycles present port 0's fields with the write strobe suppressed
        sel = grant1 ? req1 : req0;

        rsel_d  = grant1;
        rpend_d = (grant0 & ~bus.p0_write) | (grant1 & ~bus.p1_write);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsel_q  <= 1'b0;
            rpend_q <= 1'b0;
        end else begin
            rsel_q  <= rsel_d;
            rpend_q <= rpend_d;
        end
    end

    assign bus.p0_ready    = grant0;
    assign bus.p1_ready    = grant1;
    assign bus.mem_write   = any_grant & sel.write;
    assign bus.mem_wmask   = any_grant ? sel.wmask : 4'h0;
    assign bus.mem_wdata   = sel.wdata;
    assign bus.mem_wgrubby = sel.wgrubby;
    assign bus.mem_addr    = sel.addr[ADDR_WIDTH-1:0];

    assign bus.p0_rdata    = bus.mem_rdata;
    assign bus.p1_rdata    = bus.mem_rdata;
    assign bus.p0_rgrubby  = bus.mem_rgrubby;
    assign bus.p1_rgrubby  = bus.mem_rgrubby;
    assign bus.p0_rvalid   = rpend_q & (rsel_q == 1'(PORT_CPU));
    assign bus.p1_rvalid   = rpend_q & (rsel_q == 1'(PORT_AUX));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: behavioural memory, read responses checked by a scoreboard monitor.
module tb_mem_arbiter;

    localparam int AW = 14;
    localparam int SL = 8;

    typedef struct {
        logic        port;
        logic [31:0] dat;
        logic        grb;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    logic [31:0] exp0_dat, exp1_dat;
    logic        exp0_grb, exp1_grb;

    logic [31:0] mem_d [0:255];
    logic        mem_g [0:255];

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

    mem_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(SL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // memory preload: word a holds 0xA00000aa, grubby = a[0]
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) begin
                mem_d[i] <= 32'hA000_0000 | 32'(i);
                mem_g[i] <= 1'(i & 1);
            end
            bus.mem_rdata   <= 32'h0;
            bus.mem_rgrubby <= 1'b0;
        end else begin
            if (bus.mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_wmask[b]) mem_d[bus.mem_addr[7:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
                mem_g[bus.mem_addr[7:0]] <= bus.mem_wgrubby;
            end
            bus.mem_rdata   <= mem_d[bus.mem_addr[7:0]];
            bus.mem_rgrubby <= mem_g[bus.mem_addr[7:0]];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic set_p0(input logic v, input logic w, input logic [3:0] m, input logic [31:0] d,
                          input logic [AW-1:0] a, input logic [31:0] ed, input logic eg);
        bus.p0_valid = v; bus.p0_write = w; bus.p0_wmask = m; bus.p0_wdata = d;
        bus.p0_wgrubby = 1'b0; bus.p0_addr = a; exp0_dat = ed; exp0_grb = eg;
    endtask

    task automatic set_p1(input logic v, input logic w, input logic [3:0] m, input logic [31:0] d,
                          input logic g, input logic [AW-1:0] a, input logic [31:0] ed, input logic eg);
        bus.p1_valid = v; bus.p1_write = w; bus.p1_wmask = m; bus.p1_wdata = d;
        bus.p1_wgrubby = g; bus.p1_addr = a; exp1_dat = ed; exp1_grb = eg;
    endtask

    task automatic step(input logic r0, input logic r1, input string nm);
        @(negedge clk);
        chk({nm, "_p0_ready"}, 32'(bus.p0_ready), 32'(r0));
        chk({nm, "_p1_ready"}, 32'(bus.p1_ready), 32'(r1));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        set_p0(0, 0, 4'h0, 32'h0, '0, 32'h0, 1'b0);
        set_p1(0, 0, 4'h0, 32'h0, 1'b0, '0, 32'h0, 1'b0);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, "idle");
    endtask

    initial begin
        set_p0(0, 0, 4'h0, 32'h0, '0, 32'h0, 1'b0);
        set_p1(0, 0, 4'h0, 32'h0, 1'b0, '0, 32'h0, 1'b0);
        fork
            forever begin : monitor
                exp_t e;
                @(negedge clk);
                if (!rst) begin
                    if (bus.p0_rvalid && bus.p1_rvalid) begin
                        checks++; errors++;
                        $display("FAIL both_rvalid actual=11 expected=one-hot");
                    end else if (bus.p0_rvalid || bus.p1_rvalid) begin
                        if (q.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL unexpected_rvalid actual p0=%b p1=%b expected none",
                                     bus.p0_rvalid, bus.p1_rvalid);
                        end else begin
                            e = q.pop_front();
                            chk("rsp_port",   32'(bus.p1_rvalid), 32'(e.port));
                            chk("rsp_data",   bus.p1_rvalid ? bus.p1_rdata : bus.p0_rdata, e.dat);
                            chk("rsp_grubby", 32'(bus.p1_rvalid ? bus.p1_rgrubby : bus.p0_rgrubby), 32'(e.grb));
                        end
                    end
                    if (bus.p0_valid && bus.p0_ready && !bus.p0_write) q.push_back('{1'b0, exp0_dat, exp0_grb});
                    if (bus.p1_valid && bus.p1_ready && !bus.p1_write) q.push_back('{1'b1, exp1_dat, exp1_grb});
                end
            end
            begin : stimulus
                // reset state; ready follows inputs during reset
                set_p0(1, 0, 4'h0, 32'h0, 14'h10, 32'h0, 1'b0);
                #2;
                chk("rst_p0_ready",  32'(bus.p0_ready), 32'd1);
                chk("rst_p0_rvalid", 32'(bus.p0_rvalid), 32'd0);
                chk("rst_p1_rvalid", 32'(bus.p1_rvalid), 32'd0);
                chk("rst_mem_addr",  32'(bus.mem_addr), 32'h10);
                set_p0(0, 0, 4'h0, 32'h0, '0, 32'h0, 1'b0);
                @(posedge clk); @(posedge clk); #1;
                rst = 1'b0;

                // port 0 back-to-back reads
                set_p0(1, 0, 4'h0, 32'h0, 14'h10, 32'hA000_0010, 1'b0); step(1, 0, "p0rd0");
                set_p0(1, 0, 4'h0, 32'h0, 14'h11, 32'hA000_0011, 1'b1); step(1, 0, "p0rd1");
                set_p0(1, 0, 4'h0, 32'h0, 14'h12, 32'hA000_0012, 1'b0); step(1, 0, "p0rd2");
                idle(2);
                chk("q_empty_p0rd", 32'(q.size()), 32'd0);

                // port 1 write then read back
                set_p1(1, 1, 4'hF, 32'hDEAD_BEEF, 1'b1, 14'h20, 32'h0, 1'b0);
                #1;
                chk("p1wr_mem_write", 32'(bus.mem_write), 32'd1);
                chk("p1wr_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
                step(0, 1, "p1wr");
                set_p1(1, 0, 4'h0, 32'h0, 1'b0, 14'h20, 32'hDEAD_BEEF, 1'b1); step(0, 1, "p1rd");
                idle(2);
                chk("q_empty_p1", 32'(q.size()), 32'd0);

                // contention: 8 port-0 grants then one forced port-1 grant
                set_p0(1, 0, 4'h0, 32'h0, 14'h10, 32'hA000_0010, 1'b0);
                set_p1(1, 0, 4'h0, 32'h0, 1'b0, 14'h11, 32'hA000_0011, 1'b1);
                for (int k = 1; k <= 27; k++) step(k % 9 != 0, k % 9 == 0, "starve");
                idle(2);
                chk("q_empty_starve", 32'(q.size()), 32'd0);

                // alternating ports in consecutive cycles
                set_p0(1, 0, 4'h0, 32'h0, 14'h30, 32'hA000_0030, 1'b0); step(1, 0, "alt0");
                set_p0(0, 0, 4'h0, 32'h0, '0, 32'h0, 1'b0);
                set_p1(1, 0, 4'h0, 32'h0, 1'b0, 14'h31, 32'hA000_0031, 1'b1); step(0, 1, "alt1");
                idle(2);
                chk("q_empty_alt", 32'(q.size()), 32'd0);

                // byte-masked write
                set_p0(1, 1, 4'hF, 32'hAAAA_AAAA, 14'h40, 32'h0, 1'b0); step(1, 0, "wm0");
                set_p0(1, 1, 4'h5, 32'h1122_3344, 14'h40, 32'h0, 1'b0); step(1, 0, "wm1");
                set_p0(1, 0, 4'h0, 32'h0, 14'h40, 32'hAA22_AA44, 1'b0); step(1, 0, "wmrd");
                idle(2);
                chk("q_empty_wmask", 32'(q.size()), 32'd0);

                // reset in the cycle after a port 1 read is accepted
                set_p1(1, 0, 4'h0, 32'h0, 1'b0, 14'h21, 32'hA000_0021, 1'b1); step(0, 1, "rstrd");
                chk("pre_rst_p1_rvalid", 32'(bus.p1_rvalid), 32'd1);
                set_p1(0, 0, 4'h0, 32'h0, 1'b0, '0, 32'h0, 1'b0);
                rst = 1'b1;
                #1;
                chk("mid_rst_p1_rvalid", 32'(bus.p1_rvalid), 32'd0);
                q.delete();
                @(posedge clk); #1;
                rst = 1'b0;

                // starvation count cleared by reset
                set_p0(1, 0, 4'h0, 32'h0, 14'h10, 32'hA000_0010, 1'b0);
                set_p1(1, 0, 4'h0, 32'h0, 1'b0, 14'h11, 32'hA000_0011, 1'b1);
                for (int k = 0; k < 3; k++) step(1, 0, "prerst");
                chk("starve_cnt_3", 32'(dut.u_starve.cnt_q), 32'd3);
                set_p0(0, 0, 4'h0, 32'h0, '0, 32'h0, 1'b0);
                set_p1(0, 0, 4'h0, 32'h0, 1'b0, '0, 32'h0, 1'b0);
                rst = 1'b1;
                #1;
                chk("rst_starve_cnt", 32'(dut.u_starve.cnt_q), 32'd0);
                chk("rst_p0_rvalid2", 32'(bus.p0_rvalid), 32'd0);
                q.delete();
                @(posedge clk); #1;
                rst = 1'b0;

                // normal arbitration after reset
                set_p0(1, 0, 4'h0, 32'h0, 14'h12, 32'hA000_0012, 1'b0);
                set_p1(1, 0, 4'h0, 32'h0, 1'b0, 14'h13, 32'hA000_0013, 1'b1);
                step(1, 0, "post0");
                set_p0(0, 0, 4'h0, 32'h0, '0, 32'h0, 1'b0);
                step(0, 1, "post1");
                idle(2);
                chk("q_empty_post", 32'(q.size()), 32'd0);

                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        join_any
    end

endmodule
